// File: rtl/ds_box_scaler.sv
// Streaming FACTOR x FACTOR box-average / decimate video downscaler with a per-block partial-sum line buffer.
// Optional: define DS_BOX_ROUND_EN for round-half-up averaging (clamped); default truncates.
module ds_box_scaler #(
    parameter int WIDTH  = 10,
    parameter int CH     = 3,
    parameter int HACT   = 1920,
    parameter int FACTOR = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_vsync,
    input  logic                i_hsync,
    input  logic                i_de,
    input  logic [CH*WIDTH-1:0] i_data,
    input  logic                i_mode,
    output logic                o_vsync,
    output logic                o_hsync,
    output logic                o_de,
    output logic [CH*WIDTH-1:0] o_data
);

    localparam int CF   = $clog2(FACTOR);
    localparam int NBLK = HACT / FACTOR;
    localparam int BIDX = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int BLKW = BIDX + 1;
    localparam int COLW = $clog2(HACT + 1);
    localparam int HW   = WIDTH + CF;
    localparam int BW   = WIDTH + 2 * CF;
    localparam int DIV  = FACTOR * FACTOR;
    localparam logic [CF-1:0]   F_LAST  = CF'(FACTOR - 1);
    localparam logic [COLW-1:0] COL_END = COLW'(HACT);

    logic            vsync_q, de_q;
    logic            vs_rise, de_fall;
    logic [COLW-1:0] col_q, col_d;
    logic [CF-1:0]   hpos_q, hpos_d;
    logic [CF-1:0]   row_q, row_d;
    logic [BLKW-1:0] blk_q, blk_d;
    logic [BIDX-1:0] blk_idx;
    logic            mode_q;
    logic            pix_ok, blk_end, out_fire;

    logic [WIDTH-1:0] pix    [CH];
    logic [HW-1:0]    hsum   [CH];
    logic [BW-1:0]    bsum   [CH];
    logic [HW-1:0]    hacc_q [CH];
    logic [BW-1:0]    buf_q  [NBLK][CH];

    logic             s1_vld_q, s1_dec_q;
    logic [BW-1:0]    s1_sum_q [CH];
    logic [CH*WIDTH-1:0] odata_d, odata_q;
    logic             ode_q;
    logic [1:0]       vs_pipe_q, hs_pipe_q;

    assign vs_rise  = i_vsync & ~vsync_q;
    assign de_fall  = de_q & ~i_de;
    // Col saturates at HACT, so overlong lines stop feeding the block logic.
    assign pix_ok   = i_de && (col_q != COL_END);
    assign blk_end  = pix_ok && (hpos_q == F_LAST);
    assign out_fire = blk_end && (row_q == F_LAST);
    assign blk_idx  = blk_q[BIDX-1:0];

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        col_d  = col_q;
        hpos_d = hpos_q;
        blk_d  = blk_q;
        row_d  = row_q;
        if (de_fall) begin
            col_d  = '0;
            hpos_d = '0;
            blk_d  = '0;
            row_d  = (row_q == F_LAST) ? '0 : row_q + 1'b1;
        end else if (pix_ok) begin
            col_d = col_q + 1'b1;
            if (hpos_q == F_LAST) begin
                hpos_d = '0;
                blk_d  = blk_q + 1'b1;
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
        end
        if (vs_rise) begin
            row_d = '0;
        end
    end

    // Leftover right-edge pixels never reach hpos = FACTOR-1, so blk_idx stays below NBLK on writes.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            pix[c]  = i_data[(CH-1-c)*WIDTH +: WIDTH];
            hsum[c] = hacc_q[c] + HW'(pix[c]);
            bsum[c] = buf_q[blk_idx][c] + BW'(hsum[c]);
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments to avoid simulation races.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            col_q   <= '0;
            hpos_q  <= '0;
            blk_q   <= '0;
            row_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
            de_q    <= i_de;
            col_q   <= col_d;
            hpos_q  <= hpos_d;
            blk_q   <= blk_d;
            row_q   <= row_d;
            if (vs_rise) begin
                mode_q <= i_mode;
            end
        end
    end

    // NOTE: the partial-sum buffer is reset like ordinary flops, so no stale sums survive a reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CH; c++) begin
                hacc_q[c] <= '0;
            end
            for (int b = 0; b < NBLK; b++) begin
                for (int c = 0; c < CH; c++) begin
                    buf_q[b][c] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (pix_ok) begin
                    hacc_q[c] <= (hpos_q == '0) ? HW'(pix[c]) : hsum[c];
                end
                if (blk_end && !mode_q) begin
                    buf_q[blk_idx][c] <= (row_q == '0) ? BW'(hsum[c]) : bsum[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld_q <= 1'b0;
            s1_dec_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                s1_sum_q[c] <= '0;
            end
        end else begin
            s1_vld_q <= out_fire;
            if (out_fire) begin
                s1_dec_q <= mode_q;
                for (int c = 0; c < CH; c++) begin
                    s1_sum_q[c] <= mode_q ? BW'(pix[c]) : bsum[c];
                end
            end
        end
    end

`ifdef DS_BOX_ROUND_EN
    localparam int MAXV = (1 << WIDTH) - 1;
    logic [BW:0] rnd [CH];

    always_comb begin
        odata_d = '0;
        for (int c = 0; c < CH; c++) begin
            rnd[c] = ({1'b0, s1_sum_q[c]} + (BW+1)'(DIV / 2)) / (BW+1)'(DIV);
            odata_d[(CH-1-c)*WIDTH +: WIDTH] = s1_dec_q ? s1_sum_q[c][WIDTH-1:0] :
                (rnd[c] > (BW+1)'(MAXV)) ? WIDTH'(MAXV) : WIDTH'(rnd[c]);
        end
    end
`else
    always_comb begin
        odata_d = '0;
        for (int c = 0; c < CH; c++) begin
            odata_d[(CH-1-c)*WIDTH +: WIDTH] = s1_dec_q ? s1_sum_q[c][WIDTH-1:0] :
                WIDTH'(s1_sum_q[c] / BW'(DIV));
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ode_q     <= 1'b0;
            odata_q   <= '0;
            vs_pipe_q <= '0;
            hs_pipe_q <= '0;
        end else begin
            ode_q     <= s1_vld_q;
            odata_q   <= s1_vld_q ? odata_d : '0;
            vs_pipe_q <= {vs_pipe_q[0], i_vsync};
            hs_pipe_q <= {hs_pipe_q[0], i_hsync};
        end
    end

    assign o_de    = ode_q;
    assign o_data  = odata_q;
    assign o_vsync = vs_pipe_q[1];
    assign o_hsync = hs_pipe_q[1];

endmodule

// File: tb/tb_ds_box_scaler.sv
// Directed bench for ds_box_scaler: two instances (FACTOR=2/HACT=8 and FACTOR=3/HACT=8) share one stimulus stream.
module tb_ds_box_scaler;

    localparam int W  = 8;
    localparam int CH = 3;

    logic clk = 1'b0;
    logic rstn;
    logic i_vsync, i_hsync, i_de, i_mode;
    logic [CH*W-1:0] i_data;

    logic o_vsync2, o_hsync2, o_de2;
    logic [CH*W-1:0] o_data2;
    logic o_vsync3, o_hsync3, o_de3;
    logic [CH*W-1:0] o_data3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [CH*W-1:0] q2_data[$];
    int              q2_cyc[$];
    logic [CH*W-1:0] q3_data[$];
    int              q3_cyc[$];

    logic [CH*W-1:0] frame   [0:7][0:15];
    int              pix_cyc [0:7][0:15];

    always #5 clk = ~clk;

    ds_box_scaler #(.WIDTH(W), .CH(CH), .HACT(8), .FACTOR(2)) dut2 (
        .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
        .i_data(i_data), .i_mode(i_mode), .o_vsync(o_vsync2), .o_hsync(o_hsync2),
        .o_de(o_de2), .o_data(o_data2)
    );

    ds_box_scaler #(.WIDTH(W), .CH(CH), .HACT(8), .FACTOR(3)) dut3 (
        .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
        .i_data(i_data), .i_mode(i_mode), .o_vsync(o_vsync3), .o_hsync(o_hsync3),
        .o_de(o_de3), .o_data(o_data3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_de2 === 1'b1) begin
            q2_data.push_back(o_data2);
            q2_cyc.push_back(cyc);
        end
        if (o_de3 === 1'b1) begin
            q3_data.push_back(o_data3);
            q3_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        q2_data.delete();
        q2_cyc.delete();
        q3_data.delete();
        q3_cyc.delete();
    endtask

    task automatic fill_flat(input logic [W-1:0] v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                frame[r][c] = {v, v, v};
    endtask

    // Channel k of pixel (r,c) carries c + 16*r + k.
    task automatic fill_pattern();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                frame[r][c] = {W'(c + 16*r), W'(c + 16*r + 1), W'(c + 16*r + 2)};
    endtask

    task automatic send_vsync();
        i_vsync = 1'b1;
        tick();
        tick();
        i_vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_line(input int row, input int n);
        i_hsync = 1'b1;
        tick();
        i_hsync = 1'b0;
        tick();
        tick();
        for (int c = 0; c < n; c++) begin
            i_de   = 1'b1;
            i_data = frame[row][c];
            pix_cyc[row][c] = cyc;
            tick();
        end
        i_de   = 1'b0;
        i_data = '0;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int rows, input int n);
        send_vsync();
        for (int r = 0; r < rows; r++) send_line(r, n);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        i_vsync = 1'b1;
        i_de    = 1'b1;
        i_data  = 24'hA5C33C;
        repeat (3) tick();
        checks++;
        if ({o_vsync2, o_hsync2, o_de2, o_data2} !== 27'd0) begin
            errors++;
            $display("FAIL reset_dut2: got %h expected 0", {o_vsync2, o_hsync2, o_de2, o_data2});
        end
        checks++;
        if ({o_vsync3, o_hsync3, o_de3, o_data3} !== 27'd0) begin
            errors++;
            $display("FAIL reset_dut3: got %h expected 0", {o_vsync3, o_hsync3, o_de3, o_data3});
        end
        i_vsync = 1'b0;
        i_de    = 1'b0;
        i_data  = '0;
        tick();
        rstn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic check_flat(input string name, input logic [W-1:0] v);
        logic [CH*W-1:0] want;
        want = {v, v, v};
        checks++;
        if (q2_data.size() !== 8) begin
            errors++;
            $display("FAIL %s_count2: got %0d expected 8", name, q2_data.size());
        end
        for (int k = 0; k < q2_data.size() && k < 8; k++) begin
            checks++;
            if (q2_data[k] !== want) begin
                errors++;
                $display("FAIL %s_data2[%0d]: got %h expected %h", name, k, q2_data[k], want);
            end
            checks++;
            if (q2_cyc[k] !== pix_cyc[2*(k/4)+1][2*(k%4)+1] + 2) begin
                errors++;
                $display("FAIL %s_lat2[%0d]: got cycle %0d expected %0d", name, k, q2_cyc[k],
                         pix_cyc[2*(k/4)+1][2*(k%4)+1] + 2);
            end
        end
        checks++;
        if (q3_data.size() !== 2) begin
            errors++;
            $display("FAIL %s_count3: got %0d expected 2", name, q3_data.size());
        end
        for (int k = 0; k < q3_data.size() && k < 2; k++) begin
            checks++;
            if (q3_data[k] !== want) begin
                errors++;
                $display("FAIL %s_data3[%0d]: got %h expected %h", name, k, q3_data[k], want);
            end
        end
    endtask

    task automatic test_flat_field();
        fill_flat(8'd100);
        i_mode = 1'b0;
        clear_caps();
        i_vsync = 1'b1;
        tick();
        checks++;
        if (o_vsync2 !== 1'b0) begin
            errors++;
            $display("FAIL vsync_early: got %b expected 0", o_vsync2);
        end
        tick();
        checks++;
        if ({o_vsync2, o_vsync3} !== 2'b11) begin
            errors++;
            $display("FAIL vsync_delay: got %b expected 11", {o_vsync2, o_vsync3});
        end
        i_vsync = 1'b0;
        repeat (2) tick();
        for (int r = 0; r < 4; r++) send_line(r, 8);
        repeat (4) tick();
        check_flat("flat", 8'd100);
        checks++;
        if (o_data2 !== 24'd0) begin
            errors++;
            $display("FAIL idle_data: got %h expected 0", o_data2);
        end
    endtask

    task automatic test_max_value();
        fill_flat(8'd255);
        clear_caps();
        send_frame(3, 9);
        checks++;
        if (q3_data.size() !== 2) begin
            errors++;
            $display("FAIL max_count3: got %0d expected 2", q3_data.size());
        end
        for (int k = 0; k < q3_data.size() && k < 2; k++) begin
            checks++;
            if (q3_data[k] !== 24'hFFFFFF) begin
                errors++;
                $display("FAIL max_data3[%0d]: got %h expected ffffff", k, q3_data[k]);
            end
        end
        checks++;
        if (q2_data.size() !== 4) begin
            errors++;
            $display("FAIL max_count2: got %0d expected 4", q2_data.size());
        end
        for (int k = 0; k < q2_data.size() && k < 4; k++) begin
            checks++;
            if (q2_data[k] !== 24'hFFFFFF) begin
                errors++;
                $display("FAIL max_data2[%0d]: got %h expected ffffff", k, q2_data[k]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [CH*W-1:0] want;
`ifdef DS_BOX_ROUND_EN
        want = {8'd2, 8'd3, 8'd1};
`else
        want = {8'd1, 8'd3, 8'd0};
`endif
        fill_flat(8'd0);
        frame[0][0] = {8'd1, 8'd3, 8'd0};
        frame[0][1] = {8'd2, 8'd3, 8'd0};
        frame[1][0] = {8'd2, 8'd3, 8'd0};
        frame[1][1] = {8'd2, 8'd4, 8'd3};
        clear_caps();
        send_frame(2, 2);
        checks++;
        if (q2_data.size() !== 1) begin
            errors++;
            $display("FAIL round_count: got %0d expected 1", q2_data.size());
        end
        if (q2_data.size() > 0) begin
            checks++;
            if (q2_data[0] !== want) begin
                errors++;
                $display("FAIL round_data: got %h expected %h", q2_data[0], want);
            end
        end
        checks++;
        if (q3_data.size() !== 0) begin
            errors++;
            $display("FAIL short_line3: got %0d outputs expected 0", q3_data.size());
        end
    endtask

    task automatic test_decimate();
        logic [CH*W-1:0] want;
        int v;
        fill_pattern();
        clear_caps();
        i_mode = 1'b1;
        send_vsync();
        send_line(0, 8);
        i_mode = 1'b0;
        for (int r = 1; r < 4; r++) send_line(r, 8);
        repeat (4) tick();
        checks++;
        if (q2_data.size() !== 8) begin
            errors++;
            $display("FAIL dec_count: got %0d expected 8", q2_data.size());
        end
        for (int k = 0; k < q2_data.size() && k < 8; k++) begin
            v = 2*(k%4) + 1 + 16*(2*(k/4) + 1);
            want = {W'(v), W'(v + 1), W'(v + 2)};
            checks++;
            if (q2_data[k] !== want) begin
                errors++;
                $display("FAIL dec_data[%0d]: got %h expected %h", k, q2_data[k], want);
            end
        end
        // Next frame re-latches mode 0: block sum of ch0 is 8b+34.
        clear_caps();
        send_frame(2, 8);
        checks++;
        if (q2_data.size() !== 4) begin
            errors++;
            $display("FAIL relatch_count: got %0d expected 4", q2_data.size());
        end
        for (int k = 0; k < q2_data.size() && k < 4; k++) begin
`ifdef DS_BOX_ROUND_EN
            v = 2*k + 9;
`else
            v = 2*k + 8;
`endif
            want = {W'(v), W'(v + 1), W'(v + 2)};
            checks++;
            if (q2_data[k] !== want) begin
                errors++;
                $display("FAIL relatch_data[%0d]: got %h expected %h", k, q2_data[k], want);
            end
        end
    endtask

    task automatic test_partial_edges();
        logic [CH*W-1:0] want;
        int v;
        fill_pattern();
        i_mode = 1'b0;
        clear_caps();
        send_frame(7, 8);
        checks++;
        if (q3_data.size() !== 4) begin
            errors++;
            $display("FAIL edge_count: got %0d expected 4", q3_data.size());
        end
        for (int k = 0; k < q3_data.size() && k < 4; k++) begin
            v = ((k/2) == 0 ? 17 : 65) + 3*(k%2);
            want = {W'(v), W'(v + 1), W'(v + 2)};
            checks++;
            if (q3_data[k] !== want) begin
                errors++;
                $display("FAIL edge_data[%0d]: got %h expected %h", k, q3_data[k], want);
            end
            checks++;
            if (q3_cyc[k] !== pix_cyc[3*(k/2)+2][3*(k%2)+2] + 2) begin
                errors++;
                $display("FAIL edge_lat[%0d]: got cycle %0d expected %0d", k, q3_cyc[k],
                         pix_cyc[3*(k/2)+2][3*(k%2)+2] + 2);
            end
        end
        // Row 6 left row_phase at 1; the new vsync must restart at row 0.
        fill_flat(8'd100);
        clear_caps();
        send_frame(3, 8);
        checks++;
        if (q3_data.size() !== 2) begin
            errors++;
            $display("FAIL bottom_count: got %0d expected 2", q3_data.size());
        end
        for (int k = 0; k < q3_data.size() && k < 2; k++) begin
            checks++;
            if (q3_data[k] !== 24'h646464) begin
                errors++;
                $display("FAIL bottom_data[%0d]: got %h expected 646464", k, q3_data[k]);
            end
        end
    endtask

    task automatic test_mid_line_reset();
        fill_flat(8'd50);
        i_mode = 1'b0;
        send_vsync();
        send_line(0, 8);
        i_hsync = 1'b1;
        tick();
        i_hsync = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_de   = 1'b1;
            i_data = 24'h323232;
            tick();
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({o_vsync2, o_hsync2, o_de2, o_data2, o_vsync3, o_hsync3, o_de3, o_data3} !== 54'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h %h expected 0",
                     {o_vsync2, o_hsync2, o_de2, o_data2}, {o_vsync3, o_hsync3, o_de3, o_data3});
        end
        repeat (3) tick();
        checks++;
        if ({o_de2, o_data2, o_de3, o_data3} !== 50'd0) begin
            errors++;
            $display("FAIL midreset_hold: got %h expected 0", {o_de2, o_data2, o_de3, o_data3});
        end
        i_de   = 1'b0;
        i_data = '0;
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        fill_flat(8'd100);
        clear_caps();
        send_frame(4, 8);
        check_flat("postreset", 8'd100);
    endtask

    initial begin
        rstn    = 1'b0;
        i_vsync = 1'b0;
        i_hsync = 1'b0;
        i_de    = 1'b0;
        i_mode  = 1'b0;
        i_data  = '0;
        test_reset();
        test_flat_field();
        test_max_value();
        test_rounding();
        test_decimate();
        test_partial_edges();
        test_mid_line_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
